// File: rtl/rpc2_ctrl_rw_cmd_arbiter_pkg.sv
// Shared encodings for the RPC2 read/write command arbiter: FSM states, grant sides,
// BRESP codes and the round-robin pick rule.
package rpc2_ctrl_rw_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // Under contention the side that did not win last time gets the port.
  function automatic grant_e rr_pick(input logic wr_elig, input logic rd_elig,
                                     input grant_e last);
    if (wr_elig && rd_elig) return (last == GRANT_WR) ? GRANT_RD : GRANT_WR;
    return wr_elig ? GRANT_WR : GRANT_RD;
  endfunction

endpackage

// File: rtl/rpc2_ctrl_rw_cmd_arbiter_if.sv
// Command/response bundle between the AXI queues, the RPC2 IP command port and the
// bdat FIFO; master is the arbiter, slave is its environment.
interface rpc2_ctrl_rw_cmd_arbiter_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 8
);
  logic                    wr_cmd_valid;
  logic [C_ADDR_WIDTH-1:0] wr_cmd_addr;
  logic [C_LEN_WIDTH-1:0]  wr_cmd_len;
  logic                    wr_cmd_ready;
  logic                    rd_cmd_valid;
  logic [C_ADDR_WIDTH-1:0] rd_cmd_addr;
  logic [C_LEN_WIDTH-1:0]  rd_cmd_len;
  logic                    rd_cmd_ready;
  logic                    ip_cmd_valid;
  logic                    ip_cmd_ready;
  logic                    ip_cmd_write;
  logic [C_ADDR_WIDTH-1:0] ip_cmd_addr;
  logic [C_LEN_WIDTH-1:0]  ip_cmd_len;
  logic                    ip_wr_done;
  logic [1:0]              ip_wr_error;
  logic                    ip_rd_done;
  logic                    bdat_wr_en;
  logic [1:0]              bdat_din;
  logic                    bdat_rd_en;
  logic                    rd_timeout;

  modport master (
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  ip_cmd_ready, ip_wr_done, ip_wr_error, ip_rd_done, bdat_rd_en,
    output wr_cmd_ready, rd_cmd_ready,
    output ip_cmd_valid, ip_cmd_write, ip_cmd_addr, ip_cmd_len,
    output bdat_wr_en, bdat_din, rd_timeout
  );

  modport slave (
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output ip_cmd_ready, ip_wr_done, ip_wr_error, ip_rd_done, bdat_rd_en,
    input  wr_cmd_ready, rd_cmd_ready,
    input  ip_cmd_valid, ip_cmd_write, ip_cmd_addr, ip_cmd_len,
    input  bdat_wr_en, bdat_din, rd_timeout
  );
endinterface

// File: rtl/rpc2_ctrl_rw_cmd_arbiter_wr_credit_counter.sv
// Write-credit counter: starts full, saturates at both ends, and a simultaneous
// increment and decrement leave it unchanged.
module rpc2_ctrl_wr_credit_counter #(
  parameter  int C_WR_OUTSTANDING = 4,
  localparam int CW               = $clog2(C_WR_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          nonzero
);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_WR_OUTSTANDING);

  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c, input logic up,
                                             input logic down);
    if (up && !down) return (c == CNT_MAX) ? c : c + CW'(1);
    if (down && !up) return (c == '0) ? c : c - CW'(1);
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= CNT_MAX;
    else          cnt <= sat_step(cnt, inc, dec);
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/rpc2_ctrl_rw_cmd_arbiter.sv
// Shares the RPC2 IP command port between the AXI write and read command queues,
// one transaction at a time, with write credits and a completion watchdog.
module rpc2_ctrl_rw_cmd_arbiter
  import rpc2_ctrl_rw_cmd_arbiter_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_LEN_WIDTH      = 8,
  parameter int C_WR_OUTSTANDING = 4,
  parameter int C_TIMEOUT        = 1024
) (
  input logic                        clk,
  input logic                        reset_n,
  rpc2_ctrl_rw_cmd_arbiter_if.master bus
);
  localparam int CW = $clog2(C_WR_OUTSTANDING + 1);
  localparam int TW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (C_TIMEOUT > 0) ? TW'(C_TIMEOUT - 1) : '0;

  arb_state_e              state_q, state_d;
  grant_e                  last_q, last_d, grant;
  logic [TW-1:0]           timer_q, timer_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]  len_q, len_d;
  logic                    write_q, write_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    rd_ready_q, rd_ready_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    bdat_en_q, bdat_en_d;
  logic [1:0]              bdat_din_q, bdat_din_d;
  logic                    tmo_q, tmo_d;
  logic                    wr_accept;
  logic                    wr_elig;
  logic [CW-1:0]           credit_cnt;
  logic                    credit_nonzero;

  rpc2_ctrl_wr_credit_counter #(.C_WR_OUTSTANDING(C_WR_OUTSTANDING)) u_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.bdat_rd_en),
    .dec     (wr_accept && credit_nonzero),
    .cnt     (credit_cnt),
    .nonzero (credit_nonzero)
  );

  assign wr_elig = bus.wr_cmd_valid && (credit_cnt != '0);
  assign grant   = rr_pick(wr_elig, bus.rd_cmd_valid, last_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= GRANT_RD;
      timer_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_ready_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      bdat_en_q   <= 1'b0;
      bdat_din_q  <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      write_q     <= write_d;
      wr_ready_q  <= wr_ready_d;
      rd_ready_q  <= rd_ready_d;
      cmd_valid_q <= cmd_valid_d;
      bdat_en_q   <= bdat_en_d;
      bdat_din_q  <= bdat_din_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    len_d       = len_q;
    write_d     = write_q;
    wr_ready_d  = 1'b0;
    rd_ready_d  = 1'b0;
    cmd_valid_d = cmd_valid_q;
    bdat_en_d   = 1'b0;
    bdat_din_d  = bdat_din_q;
    tmo_d       = 1'b0;
    wr_accept   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_elig || bus.rd_cmd_valid) begin
          state_d     = ST_ISSUE;
          last_d      = grant;
          cmd_valid_d = 1'b1;
          write_d     = (grant == GRANT_WR);
          if (grant == GRANT_WR) begin
            wr_ready_d = 1'b1;
            addr_d     = bus.wr_cmd_addr;
            len_d      = bus.wr_cmd_len;
          end else begin
            rd_ready_d = 1'b1;
            addr_d     = bus.rd_cmd_addr;
            len_d      = bus.rd_cmd_len;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.ip_cmd_ready) begin
          state_d     = ST_BUSY;
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          wr_accept   = write_q;
        end
      end
      ST_BUSY: begin
        timer_d = timer_q + TW'(1);
        // A completion arriving on the watchdog's last cycle takes precedence.
        if (write_q ? bus.ip_wr_done : bus.ip_rd_done) begin
          state_d = ST_IDLE;
          if (write_q) begin
            bdat_en_d  = 1'b1;
            bdat_din_d = bus.ip_wr_error;
          end
        end else if ((C_TIMEOUT != 0) && (timer_q == T_LAST)) begin
          state_d = ST_IDLE;
          if (write_q) begin
            bdat_en_d  = 1'b1;
            bdat_din_d = BRESP_SLVERR;
          end else begin
            tmo_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.wr_cmd_ready = wr_ready_q;
  assign bus.rd_cmd_ready = rd_ready_q;
  assign bus.ip_cmd_valid = cmd_valid_q;
  assign bus.ip_cmd_write = write_q;
  assign bus.ip_cmd_addr  = addr_q;
  assign bus.ip_cmd_len   = len_q;
  assign bus.bdat_wr_en   = bdat_en_q;
  assign bus.bdat_din     = bdat_din_q;
  assign bus.rd_timeout   = tmo_q;

endmodule

// File: tb/tb_rpc2_ctrl_rw_cmd_arbiter.sv
// Bench for the RPC2 command arbiter: directed scenarios plus a randomized run, all
// checked cycle by cycle against a transaction-level reference model.
module tb_rpc2_ctrl_rw_cmd_arbiter;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int OUTS = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rpc2_ctrl_rw_cmd_arbiter_if #(.C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) bus ();

  rpc2_ctrl_rw_cmd_arbiter #(
    .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW), .C_WR_OUTSTANDING(OUTS), .C_TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } cmd_t;

  cmd_t aw_q[$];
  cmd_t ar_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction in flight at a time.
  bit            m_inflight, m_accepted, m_wr, m_last_wr;
  int            m_credit, m_busy_cycles;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  bit            e_wr_ready, e_rd_ready, e_valid, e_bdat, e_tmo;
  logic [1:0]    e_din;

  task automatic model_reset();
    m_inflight = 0; m_accepted = 0; m_wr = 0; m_last_wr = 0;
    m_credit = OUTS; m_busy_cycles = 0; m_addr = '0; m_len = '0;
    e_wr_ready = 0; e_rd_ready = 0; e_valid = 0; e_bdat = 0; e_tmo = 0; e_din = '0;
  endtask

  task automatic model_step(input bit wv, input cmd_t wc, input bit rv, input cmd_t rc,
                            input bit rdy, input bit wd, input logic [1:0] werr,
                            input bit rd, input bit pop);
    bit wr_ok;
    bit accept_wr = 0;
    e_wr_ready = 0; e_rd_ready = 0; e_bdat = 0; e_tmo = 0;
    if (!m_inflight) begin
      wr_ok = wv && (m_credit > 0);
      if (wr_ok || rv) begin
        m_wr       = wr_ok && !(rv && m_last_wr);
        m_last_wr  = m_wr;
        m_inflight = 1;
        m_accepted = 0;
        e_valid    = 1;
        if (m_wr) begin e_wr_ready = 1; m_addr = wc.addr; m_len = wc.len; end
        else      begin e_rd_ready = 1; m_addr = rc.addr; m_len = rc.len; end
      end
    end else if (!m_accepted) begin
      if (rdy) begin
        m_accepted = 1; e_valid = 0; m_busy_cycles = 0; accept_wr = m_wr;
      end
    end else begin
      m_busy_cycles++;
      if (m_wr ? wd : rd) begin
        m_inflight = 0;
        if (m_wr) begin e_bdat = 1; e_din = werr; end
      end else if (m_busy_cycles == TMO) begin
        m_inflight = 0;
        if (m_wr) begin e_bdat = 1; e_din = 2'b10; end
        else e_tmo = 1;
      end
    end
    if (accept_wr && !pop) m_credit--;
    else if (pop && !accept_wr && m_credit < OUTS) m_credit++;
  endtask

  // Environment knobs and observed events.
  bit            auto_ip = 0;
  int            p_rdy = 50, p_done = 10, p_pop = 0;
  int            n_wr_pop, n_rd_pop, n_push, n_tmo;
  logic [1:0]    last_din;
  bit            both_ready;
  bit            grant_log[$];
  logic [AW-1:0] seen_addr;
  logic [LW-1:0] seen_len;
  logic          seen_write;

  task automatic step();
    cmd_t c_w, c_r;
    bit   c_wv, c_rv, c_rdy, c_wd, c_rd, c_pop;
    logic [1:0] c_err;
    c_w = '0; c_r = '0;
    if (aw_q.size() != 0) c_w = aw_q[0];
    if (ar_q.size() != 0) c_r = ar_q[0];
    c_wv = (aw_q.size() != 0);
    c_rv = (ar_q.size() != 0);
    bus.wr_cmd_valid = c_wv; bus.wr_cmd_addr = c_w.addr; bus.wr_cmd_len = c_w.len;
    bus.rd_cmd_valid = c_rv; bus.rd_cmd_addr = c_r.addr; bus.rd_cmd_len = c_r.len;
    c_rdy = bus.ip_cmd_ready; c_wd = bus.ip_wr_done; c_err = bus.ip_wr_error;
    c_rd = bus.ip_rd_done; c_pop = bus.bdat_rd_en;
    @(posedge clk);
    #1;
    model_step(c_wv, c_w, c_rv, c_r, c_rdy, c_wd, c_err, c_rd, c_pop);
    check_val("wr_cmd_ready", bus.wr_cmd_ready, e_wr_ready);
    check_val("rd_cmd_ready", bus.rd_cmd_ready, e_rd_ready);
    check_val("ip_cmd_valid", bus.ip_cmd_valid, e_valid);
    if (e_valid)
      check_val("ip_cmd_payload", {bus.ip_cmd_write, bus.ip_cmd_addr, bus.ip_cmd_len},
                {m_wr, m_addr, m_len});
    check_val("bdat_wr_en", bus.bdat_wr_en, e_bdat);
    if (e_bdat) check_val("bdat_din", bus.bdat_din, e_din);
    check_val("rd_timeout", bus.rd_timeout, e_tmo);
    if (bus.wr_cmd_ready && bus.rd_cmd_ready) both_ready = 1;
    if (bus.wr_cmd_ready) begin
      n_wr_pop++; grant_log.push_back(1'b1);
      if (aw_q.size() != 0) void'(aw_q.pop_front());
    end
    if (bus.rd_cmd_ready) begin
      n_rd_pop++; grant_log.push_back(1'b0);
      if (ar_q.size() != 0) void'(ar_q.pop_front());
    end
    if (bus.ip_cmd_valid) begin
      seen_addr = bus.ip_cmd_addr; seen_len = bus.ip_cmd_len; seen_write = bus.ip_cmd_write;
    end
    if (bus.bdat_wr_en) begin n_push++; last_din = bus.bdat_din; end
    if (bus.rd_timeout) n_tmo++;
    if (auto_ip) begin
      bus.ip_cmd_ready = ($urandom_range(99) < p_rdy);
      bus.ip_wr_done   = ($urandom_range(99) < p_done);
      bus.ip_rd_done   = ($urandom_range(99) < p_done);
      bus.ip_wr_error  = 2'($urandom_range(3));
      bus.bdat_rd_en   = ($urandom_range(99) < p_pop);
    end
  endtask

  task automatic clear_ip_inputs();
    bus.ip_cmd_ready = 0; bus.ip_wr_done = 0; bus.ip_wr_error = '0;
    bus.ip_rd_done = 0; bus.bdat_rd_en = 0;
  endtask

  task automatic do_reset();
    auto_ip = 0;
    clear_ip_inputs();
    aw_q.delete(); ar_q.delete(); grant_log.delete();
    bus.wr_cmd_valid = 0; bus.rd_cmd_valid = 0;
    @(negedge clk);
    reset_n = 0;
    #1;
    check_val("reset_outputs_zero",
              {bus.wr_cmd_ready, bus.rd_cmd_ready, bus.ip_cmd_valid, bus.ip_cmd_write,
               bus.ip_cmd_addr, bus.ip_cmd_len, bus.bdat_wr_en, bus.bdat_din, bus.rd_timeout},
              64'd0);
    model_reset();
    n_wr_pop = 0; n_rd_pop = 0; n_push = 0; n_tmo = 0; both_ready = 0; last_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!bus.ip_cmd_valid && k < max) begin step(); k++; end
    check_val(tag, bus.ip_cmd_valid, 1);
  endtask

  // Issues one command in manual mode and returns once it has been accepted.
  task automatic manual_issue(input string tag);
    wait_valid(tag, 10);
    bus.ip_cmd_ready = 1; step(); bus.ip_cmd_ready = 0;
  endtask

  task automatic run_auto(input int cycles);
    auto_ip = 1;
    repeat (cycles) step();
    auto_ip = 0;
    clear_ip_inputs();
  endtask

  initial begin
    int k, n0, w0, r0;
    clear_ip_inputs();
    bus.wr_cmd_valid = 0; bus.wr_cmd_addr = '0; bus.wr_cmd_len = '0;
    bus.rd_cmd_valid = 0; bus.rd_cmd_addr = '0; bus.rd_cmd_len = '0;

    // Single write: late accept, late completion with OKAY.
    do_reset();
    aw_q.push_back('{addr: 32'h100, len: 8'd3});
    wait_valid("t1_issue", 10);
    check_val("t1_cmd", {seen_write, seen_addr, seen_len}, {1'b1, 32'h100, 8'd3});
    step(); step();
    bus.ip_cmd_ready = 1; step(); bus.ip_cmd_ready = 0;
    repeat (9) step();
    bus.ip_wr_done = 1; bus.ip_wr_error = 2'b00; step(); bus.ip_wr_done = 0;
    repeat (2) step();
    check_val("t1_wr_pops", n_wr_pop, 1);
    check_val("t1_pushes", n_push, 1);
    check_val("t1_bresp", last_din, 2'b00);
    // One credit is now consumed: only three more writes may go out.
    w0 = n_wr_pop;
    for (int i = 0; i < 4; i++) aw_q.push_back('{addr: 32'h200 + i, len: 8'(i)});
    p_rdy = 60; p_done = 30; p_pop = 0;
    run_auto(300);
    check_val("t1_credit_left", n_wr_pop - w0, 3);

    // Contention from reset alternates starting with the write side.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      aw_q.push_back('{addr: 32'h1000 + i, len: 8'd1});
      ar_q.push_back('{addr: 32'h2000 + i, len: 8'd2});
    end
    auto_ip = 1; k = 0;
    while (grant_log.size() < 4 && k < 400) begin step(); k++; end
    auto_ip = 0; clear_ip_inputs();
    check_val("t2_grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4)
      check_val("t2_grant_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
                4'b1010);
    check_val("t2_no_double_ready", both_ready, 0);

    // Credit exhaustion: four writes go out, the read still gets through.
    do_reset();
    for (int i = 0; i < 5; i++) aw_q.push_back('{addr: 32'h3000 + i, len: 8'd0});
    ar_q.push_back('{addr: 32'h4000, len: 8'd7});
    p_pop = 0;
    run_auto(300);
    check_val("t3_writes_blocked", n_wr_pop, 4);
    check_val("t3_read_served", n_rd_pop, 1);
    bus.bdat_rd_en = 1; step(); bus.bdat_rd_en = 0;
    run_auto(100);
    check_val("t3_fifth_write", n_wr_pop, 5);

    // Watchdog on a write, on a read, and a completion landing on the last cycle.
    do_reset();
    aw_q.push_back('{addr: 32'h5000, len: 8'd4});
    manual_issue("t4_wr_issue");
    n0 = n_push; k = 0;
    while (n_push == n0 && k < 40) begin step(); k++; end
    check_val("t4_wr_tmo_cycle", k, TMO);
    check_val("t4_wr_slverr", last_din, 2'b10);
    ar_q.push_back('{addr: 32'h6000, len: 8'd4});
    manual_issue("t4_rd_issue");
    k = 0;
    while (n_tmo == 0 && k < 40) begin step(); k++; end
    check_val("t4_rd_tmo_cycle", k, TMO);
    aw_q.push_back('{addr: 32'h7000, len: 8'd4});
    manual_issue("t4_race_issue");
    n0 = n_push;
    repeat (TMO - 1) step();
    bus.ip_wr_done = 1; bus.ip_wr_error = 2'b01; step(); bus.ip_wr_done = 0;
    repeat (3) step();
    check_val("t4_race_pushes", n_push - n0, 1);
    check_val("t4_race_bresp", last_din, 2'b01);

    // Pop coinciding with a write accept, and stray completions while idle.
    do_reset();
    aw_q.push_back('{addr: 32'h8000, len: 8'd1});
    manual_issue("t5_first");
    bus.ip_wr_done = 1; step(); bus.ip_wr_done = 0; step();
    aw_q.push_back('{addr: 32'h8100, len: 8'd1});
    wait_valid("t5_second", 10);
    bus.ip_cmd_ready = 1; bus.bdat_rd_en = 1; step();
    bus.ip_cmd_ready = 0; bus.bdat_rd_en = 0;
    bus.ip_wr_done = 1; step(); bus.ip_wr_done = 0; step();
    n0 = n_push; r0 = n_tmo; w0 = n_wr_pop;
    bus.ip_rd_done = 1; step(); bus.ip_rd_done = 0;
    bus.ip_wr_done = 1; step(); bus.ip_wr_done = 0;
    repeat (2) step();
    check_val("t5_stray_done", {n_push - n0, n_tmo - r0, n_wr_pop - w0, 32'(bus.ip_cmd_valid)},
              {32'd0, 32'd0, 32'd0, 32'd0});
    for (int i = 0; i < 5; i++) aw_q.push_back('{addr: 32'h8200 + i, len: 8'd2});
    p_pop = 0;
    run_auto(300);
    check_val("t5_credit_kept", n_wr_pop - w0, 3);

    // Reset while a write is in BUSY.
    do_reset();
    aw_q.push_back('{addr: 32'h9000, len: 8'd5});
    manual_issue("t6_issue");
    repeat (3) step();
    do_reset();
    for (int i = 0; i < 5; i++) aw_q.push_back('{addr: 32'h9100 + i, len: 8'd1});
    ar_q.push_back('{addr: 32'h9900, len: 8'd3});
    p_pop = 0;
    run_auto(300);
    check_val("t6_first_grant_wr", (grant_log.size() != 0) ? grant_log[0] : 1'b0, 1'b1);
    check_val("t6_credit_full", n_wr_pop, 4);
    check_val("t6_read_served", n_rd_pop, 1);

    // Randomized traffic.
    do_reset();
    p_rdy = 50; p_done = 10; p_pop = 25;
    auto_ip = 1;
    for (int c = 0; c < 4000; c++) begin
      if (aw_q.size() < 4 && $urandom_range(3) == 0)
        aw_q.push_back('{addr: $urandom, len: 8'($urandom_range(255))});
      if (ar_q.size() < 4 && $urandom_range(3) == 0)
        ar_q.push_back('{addr: $urandom, len: 8'($urandom_range(255))});
      step();
    end
    auto_ip = 0;
    check_val("rand_no_double_ready", both_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
